// File: rtl/shift_add_mult_ctrl.sv
// Controller and accumulator for a sequential shift-add multiplier that drives an
// external M-bit PISO holding the multiplier and, at the end, the product low half.
//
// state  | meaning
// IDLE   | waiting for start, acc holds the last product high half
// LOAD   | PISO captures the multiplier on the closing edge
// RUN    | M add/shift iterations, one per cycle
// DONE   | one-cycle completion pulse
module shift_add_mult_ctrl #(
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] multiplicand,
  input  logic         q_lsb,
  output logic         piso_load,
  output logic         piso_shift,
  output logic         piso_shift_in,
  output logic [M-1:0] acc_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(M) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [M-1:0]   acc;
  logic [M-1:0]   mcand_reg;
  logic [CW-1:0]  cnt;
  logic [M:0]     sum;

  // Kept one bit wider than acc so the carry survives into the shifted acc.
  assign sum           = {1'b0, acc} + {1'b0, (q_lsb ? mcand_reg : {M{1'b0}})};
  assign piso_shift_in = (state == S_RUN) & sum[0];
  assign acc_out       = acc;

  // Strobes are registered from the next state so they stay pure Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      mcand_reg  <= '0;
      cnt        <= '0;
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand_reg <= multiplicand;
            acc       <= '0;
            cnt       <= '0;
            state     <= S_LOAD;
            piso_load <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          state      <= S_RUN;
          piso_load  <= 1'b0;
          piso_shift <= 1'b1;
        end
        S_RUN: begin
          acc <= sum[M:1];
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state      <= S_DONE;
            piso_shift <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          piso_load  <= 1'b0;
          piso_shift <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: models the neighbouring PISO and checks every
// product against plain 32-bit multiplication.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic        q_lsb;
  logic        piso_load;
  logic        piso_shift;
  logic        piso_shift_in;
  logic [15:0] acc_out;
  logic        busy;
  logic        done;

  logic [15:0] piso;
  logic [15:0] mult_in;

  int checks = 0;
  int errors = 0;

  shift_add_mult_ctrl #(.M(16)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
    .q_lsb(q_lsb), .piso_load(piso_load), .piso_shift(piso_shift),
    .piso_shift_in(piso_shift_in), .acc_out(acc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Neighbouring PISO: load has priority, shift moves right with shift_in at the MSB.
  assign q_lsb = piso[0];
  always @(posedge clk) begin
    if (rst)             piso <= '0;
    else if (piso_load)  piso <= mult_in;
    else if (piso_shift) piso <= {piso_shift_in, piso[15:1]};
  end

  // Runs one multiply; hold keeps start high, pulse_at re-pulses start at that edge count.
  task automatic mult_op(input logic [15:0] a, input logic [15:0] b, input bit hold,
                         input int pulse_at, output logic [31:0] got, output int lat,
                         output int nload, output int nshift, output bit busy_ok,
                         output bit strobe_ok, output bit timeout, output time t_done);
    @(negedge clk);
    start = 1'b1; multiplicand = a; mult_in = b;
    @(posedge clk);
    lat = 0; nload = 0; nshift = 0; busy_ok = 1; strobe_ok = 1; timeout = 1; t_done = 0;
    got = '0;
    repeat (40) begin
      @(negedge clk);
      start = hold || (lat == pulse_at);
      multiplicand = 16'($urandom);
      if (piso_load) nload++;
      if (piso_shift) nshift++;
      if (piso_load && piso_shift) strobe_ok = 0;
      if (!piso_shift && piso_shift_in) strobe_ok = 0;
      if (done) begin
        timeout = 0; t_done = $time; got = {acc_out, piso};
        break;
      end
      if (!busy) busy_ok = 0;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; multiplicand = '0; mult_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (acc_out !== 16'h0) begin errors++; $display("FAIL reset_acc got %h want 0000", acc_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (piso_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", piso_load); end
    checks++; if (piso_shift !== 1'b0) begin errors++; $display("FAIL reset_shift got %b want 0", piso_shift); end
    checks++; if (piso_shift_in !== 1'b0) begin errors++; $display("FAIL reset_shift_in got %b want 0", piso_shift_in); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] av[4] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] bv[4] = '{16'h0005, 16'hFFFF, 16'h0002, 16'h0000};
    logic [31:0] got, exp;
    int lat, nl, ns; bit bok, sok, to; time td;
    for (int i = 0; i < 4; i++) begin
      exp = 32'(av[i]) * 32'(bv[i]);
      mult_op(av[i], bv[i], 0, -1, got, lat, nl, ns, bok, sok, to, td);
      checks++; if (to) begin errors++; $display("FAIL dir_timeout op %0d no done within 40 edges", i); end
      checks++; if (got !== exp) begin errors++; $display("FAIL dir_product op %0d got %h want %h", i, got, exp); end
      checks++; if (lat !== 17) begin errors++; $display("FAIL dir_latency op %0d got %0d want 17", i, lat); end
      checks++; if (nl !== 1 || ns !== 16) begin errors++; $display("FAIL dir_strobes op %0d load %0d shift %0d want 1 16", i, nl, ns); end
      checks++; if (!bok || !sok) begin errors++; $display("FAIL dir_busy_strobe op %0d busy_ok %0b strobe_ok %0b want 1 1", i, bok, sok); end
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b0 || acc_out !== exp[31:16] || piso !== exp[15:0]) begin
        errors++; $display("FAIL dir_hold op %0d done %b acc %h piso %h want 0 %h %h", i, done, acc_out, piso, exp[31:16], exp[15:0]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [15:0] a, b; logic [31:0] got;
    int lat, nl, ns; bit bok, sok, to; time td;
    a = 16'($urandom) | 16'h1; b = 16'($urandom) | 16'h8000;
    mult_op(a, b, 0, 6, got, lat, nl, ns, bok, sok, to, td);
    checks++; if (to || got !== 32'(a) * 32'(b)) begin errors++; $display("FAIL ign_product got %h want %h timeout %0b", got, 32'(a) * 32'(b), to); end
    checks++; if (!bok || lat !== 17 || nl !== 1) begin errors++; $display("FAIL ign_busy busy_ok %0b lat %0d loads %0d want 1 17 1", bok, lat, nl); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got; int lat, nl, ns, dseen; bit bok, sok, to; time td;
    @(negedge clk);
    start = 1'b1; multiplicand = 16'($urandom) | 16'h8001; mult_in = 16'hFFFF;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (acc_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || piso_load !== 1'b0 || piso_shift !== 1'b0) begin
      errors++; $display("FAIL abort_state acc %h busy %b done %b load %b shift %b want 0 0 0 0 0", acc_out, busy, done, piso_load, piso_shift);
    end
    rst = 1'b0; dseen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dseen++; end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", dseen); end
    mult_op(16'd7, 16'd9, 0, -1, got, lat, nl, ns, bok, sok, to, td);
    checks++; if (to || got !== 32'h0000_003F) begin errors++; $display("FAIL abort_fresh got %h want 0000003f timeout %0b", got, to); end
  endtask

  task automatic test_random();
    logic [15:0] a, b; logic [31:0] got;
    int lat, nl, ns; bit bok, sok, to; time td;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      mult_op(a, b, 0, -1, got, lat, nl, ns, bok, sok, to, td);
      checks++; if (to || got !== 32'(a) * 32'(b) || lat !== 17 || !sok) begin
        errors++; $display("FAIL rand op %0d %h*%h got %h want %h lat %0d strobe_ok %0b", i, a, b, got, 32'(a) * 32'(b), lat, sok);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b; logic [31:0] got;
    int lat, nl, ns; bit bok, sok, to; time td, tprev;
    tprev = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      mult_op(a, b, 1, -1, got, lat, nl, ns, bok, sok, to, td);
      checks++; if (to || got !== 32'(a) * 32'(b)) begin
        errors++; $display("FAIL b2b_product op %0d got %h want %h timeout %0b", i, got, 32'(a) * 32'(b), to);
      end
      if (i > 0) begin
        checks++; if (td - tprev !== 190) begin errors++; $display("FAIL b2b_period op %0d got %0t want 190", i, td - tprev); end
      end
      tprev = td;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Controller and accumulator for the sequential shift-add multiplier.
- Sits directly beside the 16-bit multiplier PISO shift register:
  - drives that register's load, shift and shift_in;
  - consumes its LSB (data_out[0]) as the current multiplier bit.
- Each of M iterations conditionally adds the multiplicand into the accumulator. The combined {carry, acc} then shifts right, with acc LSB entering the PISO MSB.
- At completion, the high half of the product is on acc_out and the low half sits in the PISO.

Parameters:
- M, 16, operand width. Must match the PISO width. Product is 2*M bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset. Shared with the PISO.
- start  input  1  request a multiply. Sampled only in IDLE.
- multiplicand  input  M  captured on the edge that accepts start.
- q_lsb  input  1  PISO data_out[0], the current multiplier bit.
- piso_load  output  1  PISO load strobe. Upstream holds the multiplier on PISO data_in during this cycle.
- piso_shift  output  1  PISO shift strobe.
- piso_shift_in  output  1  bit shifted into PISO MSB.
- acc_out  output  M  accumulator, i.e. high product half.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on rising clk only.
- Reset state:
  - state = IDLE; acc, mcand_reg and bit counter cleared.
  - piso_load, piso_shift, piso_shift_in, busy, done all 0; acc_out = 0.
- Reset mid-operation aborts immediately to this state, with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE. All strobe outputs are decoded from state (Moore).
- IDLE:
  - Outputs 0; acc holds the previous result.
  - start = 1: mcand_reg <= multiplicand, acc <= 0, cnt <= 0, go to LOAD.
- LOAD:
  - piso_load = 1 and busy = 1 for exactly one cycle; the PISO captures the multiplier on the closing edge.
  - Go to RUN.
- RUN (exactly M cycles; busy = 1, piso_shift = 1):
  - sum[M:0] = acc + (q_lsb ? mcand_reg : 0), computed M+1 bits wide so the carry is kept.
  - piso_shift_in = sum[0], combinational within the cycle.
  - acc <= sum[M:1]; cnt <= cnt + 1.
  - When cnt == M-1, go to DONE.
- DONE:
  - done = 1 for one cycle, busy = 0; go to IDLE.
  - acc_out = product[2M-1:M]; PISO data_out = product[M-1:0].
  - Both hold until the next accepted start.
- Latency: the edge that samples start, plus M+1 edges, gives done high (17 edges for M=16). Throughput is one multiply per M+3 cycles.
- piso_shift_in = 0 whenever not in RUN. piso_load and piso_shift are never high together.
- start in LOAD, RUN or DONE is ignored, with no queuing. A new start is accepted earliest in the IDLE cycle after DONE.
- multiplicand may change freely after the start edge.
- The counter is wide enough for M (clog2(M)+1 bits). It does not wrap within an operation.
- Operands are unsigned. There is no overflow: the 2M-bit product is always exact.

Test Plan:
- 0x0003 × 0x0005 -> done 17 edges after start; acc_out = 0x0000, PISO = 0x000F; exactly 1 load cycle and 16 shift cycles observed.
- 0xFFFF × 0xFFFF -> acc_out = 0xFFFE, PISO = 0x0001. Exercises the carry into sum[M] on every iteration.
- 0x8000 × 0x0002 -> acc_out = 0x0001, PISO = 0x0000. Then 0x1234 × 0x0000 -> acc_out = 0, PISO = 0.
- start pulsed again in RUN cycle 5 with a different multiplicand -> ignored; the result equals the first operation only. busy stays high continuously until DONE.
- rst asserted in RUN cycle 8 -> next cycle state IDLE, acc_out = 0, busy = done = 0, no done pulse. A fresh 7 × 9 then yields acc_out = 0, PISO = 0x003F.
- Back-to-back: start held high continuously -> operations accepted every M+3 cycles. Each done shows the correct product for random operand pairs, checked against a 32-bit reference model.
